// File: rtl/corr_metric_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : corr_metric_pkg                                                 |
// | Brief    : Shared types and constants for the correlator metric consumer.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package corr_metric_pkg;

  // Packet collection vs. serial division in progress
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DIV     = 1'b1
  } state_e;

  // Packet layout: one byte per field, in arrival order
  localparam int PKT_LEN = 5;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] IDX_WINNUM  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_X       = 3'd1;
  localparam logic [IDX_W-1:0] IDX_Y       = 3'd2;
  localparam logic [IDX_W-1:0] IDX_ISECT   = 3'd3;
  localparam logic [IDX_W-1:0] IDX_SYMDIFF = 3'd4;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_SYMDIFF;

  // Serial divider: one quotient bit per cycle over a 16-bit dividend
  localparam int DIV_ITER  = 16;
  localparam int DIV_CNT_W = 4;

  // Offset that maps the signed covariance onto an unsigned byte
  localparam int COV_OFFSET = 128;

  // Offset-binary covariance: ({isect,8'h00} - x*y) >>> 8, plus offset, clamped to a byte.
  // 18 bits signed covers +65280 .. -65025 without overflow.
  function automatic logic [7:0] cov_metric(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] isect
  );
    logic        [15:0] prod;
    logic signed [17:0] c;
    logic signed [17:0] s;
    logic        [7:0]  res;
    prod = 16'(x) * 16'(y);
    c    = $signed({2'b00, isect, 8'h00}) - $signed({2'b00, prod});
    s    = (c >>> 8) + $signed(18'(COV_OFFSET));
    if (s < 0) begin
      res = 8'h00;
    end else if (s > 18'sd255) begin
      res = 8'hFF;
    end else begin
      res = s[7:0];
    end
    return res;
  endfunction

endpackage : corr_metric_pkg
`default_nettype wire

// File: rtl/corr_metric_divSerial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : divSerial                                                       |
// | Brief    : 16/8 restoring serial divider, one quotient bit per cycle.      |
// |            o_done/o_quot are presented combinationally during the final    |
// |            iteration so the consumer can register the result on that edge.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module divSerial
  import corr_metric_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_abort,
  input  logic        i_load,
  input  logic [15:0] i_dividend,
  input  logic [7:0]  i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_quot
);

  logic                 busy_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [15:0]          quot_q;   // holds remaining dividend bits, quotient shifts in at LSB
  logic [7:0]           rem_q;
  logic [7:0]           den_q;

  logic [8:0]  w_remShift;
  logic        w_fits;
  logic [8:0]  w_trial;
  logic [7:0]  w_remNext;
  logic [15:0] w_quotNext;
  logic        w_lastIter;

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    w_remShift = {rem_q, quot_q[15]};
    w_fits     = (w_remShift >= {1'b0, den_q});
    w_trial    = w_remShift - {1'b0, den_q};
    // When the trial does not fit, the shifted remainder is below den_q and so fits in 8 bits
    w_remNext  = w_fits ? w_trial[7:0] : w_remShift[7:0];
    w_quotNext = {quot_q[14:0], w_fits};
  end

  assign w_lastIter = (cnt_q == DIV_CNT_W'(DIV_ITER - 1));
  assign o_busy     = busy_q;
  assign o_done     = busy_q & i_en & ~i_abort & w_lastIter;
  assign o_quot     = w_quotNext;

  // Iteration state; abort has priority over a new load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else if (i_en) begin
      if (i_abort) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (i_load) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        quot_q <= i_dividend;
        rem_q  <= '0;
        den_q  <= i_divisor;
      end else if (busy_q) begin
        quot_q <= w_quotNext;
        rem_q  <= w_remNext;
        cnt_q  <= cnt_q + DIV_CNT_W'(1);
        if (w_lastIter) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

endmodule : divSerial
`default_nettype wire

// File: rtl/corr_metric.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : corr_metric                                                     |
// | Brief    : Collects 5-byte correlator window packets and produces the Ham, |
// |            Cov and Dep metrics, with window-number continuity checking.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module corr_metric
  import corr_metric_pkg::*;
#(
  parameter bit CHECK_SEQ   = 1'b1,
  parameter bit DEP_DENOM_X = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cg,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_winNum,
  output logic [7:0] o_ham,
  output logic [7:0] o_cov,
  output logic [7:0] o_dep,
  output logic       o_valid,
  output logic       o_seqErr
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pkt_q [PKT_LEN];
  logic [7:0]       pkt_d [PKT_LEN];
  logic [7:0]       ham_q, ham_d;
  logic [7:0]       cov_q, cov_d;
  logic [7:0]       dep_q, dep_d;
  logic [7:0]       win_q, win_d;
  logic             valid_q, valid_d;
  logic             seqErr_q, seqErr_d;
  logic             armed_q, armed_d;

  logic        w_collect;
  logic        w_accept;
  logic        w_lastByte;
  logic        w_divLoad;
  logic [7:0]  w_denom;
  logic        w_divBusy;
  logic        w_divDone;
  logic [15:0] w_quot;
  logic [7:0]  w_dep;
  logic        w_seqBad;

  assign w_collect  = (state_q == COLLECT);
  // A flush in the same cycle drops the byte rather than storing it
  assign w_accept   = i_cg & i_valid & w_collect & ~i_flush;
  assign w_lastByte = (idx_q == IDX_LAST);
  assign w_divLoad  = w_accept & w_lastByte;
  assign w_denom    = DEP_DENOM_X ? pkt_q[IDX_X] : pkt_q[IDX_Y];

  // isect is already stored when the final byte arrives, so the divider loads from registers
  divSerial u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_cg),
    .i_abort    (i_flush),
    .i_load     (w_divLoad),
    .i_dividend ({pkt_q[IDX_ISECT], 8'h00}),
    .i_divisor  (w_denom),
    .o_busy     (w_divBusy),
    .o_done     (w_divDone),
    .o_quot     (w_quot)
  );

  // Dep: zero denominator reports 0, quotients above a byte saturate
  always_comb begin
    if (w_denom == 8'h00) begin
      w_dep = 8'h00;
    end else if (|w_quot[15:8]) begin
      w_dep = 8'hFF;
    end else begin
      w_dep = w_quot[7:0];
    end
  end

  generate
    if (CHECK_SEQ) begin : g_seqChk
      assign w_seqBad = armed_q & (pkt_q[IDX_WINNUM] != (win_q + 8'd1));
    end else begin : g_seqOff
      assign w_seqBad = 1'b0;
    end
  endgenerate

  // Next-state: packet collection, result capture and flush handling
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pkt_d    = pkt_q;
    ham_d    = ham_q;
    cov_d    = cov_q;
    dep_d    = dep_q;
    win_d    = win_q;
    valid_d  = 1'b0;
    seqErr_d = seqErr_q;
    armed_d  = armed_q;

    if (i_flush) begin
      // Realign: metric outputs keep their last values
      state_d  = COLLECT;
      idx_d    = '0;
      armed_d  = 1'b0;
      seqErr_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (w_accept) begin
            pkt_d[idx_q] = i_data;
            if (w_lastByte) begin
              idx_d   = '0;
              state_d = DIV;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        DIV: begin
          if (w_divDone) begin
            state_d = COLLECT;
            ham_d   = 8'hFF - pkt_q[IDX_SYMDIFF];
            cov_d   = cov_metric(pkt_q[IDX_X], pkt_q[IDX_Y], pkt_q[IDX_ISECT]);
            dep_d   = w_dep;
            win_d   = pkt_q[IDX_WINNUM];
            valid_d = 1'b1;
            armed_d = 1'b1;
            if (w_seqBad) begin
              seqErr_d = 1'b1;
            end
          end else if (!w_divBusy) begin
            // Divider idle while waiting on it: recover instead of stalling forever
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // State registers; a low clock-gate enable freezes everything
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      for (int i = 0; i < PKT_LEN; i++) begin
        pkt_q[i] <= '0;
      end
      ham_q    <= '0;
      cov_q    <= '0;
      dep_q    <= '0;
      win_q    <= '0;
      valid_q  <= 1'b0;
      seqErr_q <= 1'b0;
      armed_q  <= 1'b0;
    end else if (i_cg) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pkt_q    <= pkt_d;
      ham_q    <= ham_d;
      cov_q    <= cov_d;
      dep_q    <= dep_d;
      win_q    <= win_d;
      valid_q  <= valid_d;
      seqErr_q <= seqErr_d;
      armed_q  <= armed_d;
    end
  end

  assign o_ready  = w_collect;
  assign o_winNum = win_q;
  assign o_ham    = ham_q;
  assign o_cov    = cov_q;
  assign o_dep    = dep_q;
  assign o_valid  = valid_q & i_cg;
  assign o_seqErr = seqErr_q;

endmodule : corr_metric
`default_nettype wire

// File: tb/tb_corr_metric.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_corr_metric                                                  |
// | Brief    : Self-checking bench for corr_metric with a behavioural model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_corr_metric;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cg    = 1'b1;
  logic       i_flush = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] o_winNum, o_ham, o_cov, o_dep;
  logic       o_valid, o_seqErr;

  corr_metric dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_cg     (i_cg),
    .i_flush  (i_flush),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_winNum (o_winNum),
    .o_ham    (o_ham),
    .o_cov    (o_cov),
    .o_dep    (o_dep),
    .o_valid  (o_valid),
    .o_seqErr (o_seqErr)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit       m_armed  = 1'b0;
  bit       m_seqErr = 1'b0;
  int       m_prev   = 0;
  int       e_ham, e_cov, e_dep, e_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected metrics for one packet, computed with plain integer arithmetic
  task automatic model_pkt(input int w, input int x, input int y, input int is, input int sd);
    int c, fl, s, q;
    e_ham = 255 - sd;
    c = is * 256 - x * y;
    fl = (c >= 0) ? (c / 256) : -((-c + 255) / 256);
    s = fl + 128;
    e_cov = (s < 0) ? 0 : ((s > 255) ? 255 : s);
    if (y == 0) e_dep = 0;
    else begin
      q = (is * 256) / y;
      e_dep = (q > 255) ? 255 : q;
    end
    if (m_armed && (w != ((m_prev + 1) % 256))) m_seqErr = 1'b1;
    m_armed = 1'b1;
    m_prev  = w;
    e_win   = w;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ham"}, o_ham, e_ham);
    check({tag, "_cov"}, o_cov, e_cov);
    check({tag, "_dep"}, o_dep, e_dep);
    check({tag, "_win"}, o_winNum, e_win);
    check({tag, "_seq"}, o_seqErr, m_seqErr);
  endtask

  // Presents one byte, optionally after idle cycles; returns just after the accepting edge
  task automatic put_byte(input logic [7:0] b, input int gap);
    i_valid = 1'b0;
    repeat (gap) @(posedge i_clk);
    #1;
    i_data  = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] w, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] is, input logic [7:0] sd, input int max_gap);
    put_byte(w,  $urandom_range(0, max_gap));
    put_byte(x,  $urandom_range(0, max_gap));
    put_byte(y,  $urandom_range(0, max_gap));
    put_byte(is, $urandom_range(0, max_gap));
    put_byte(sd, $urandom_range(0, max_gap));
  endtask

  // Waits (bounded) for o_valid, checks latency from the last byte, outputs and pulse width
  task automatic wait_result(input int exp_lat, input string tag);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(negedge i_clk);
      cnt++;
      if (o_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, cnt, exp_lat);
    if (seen) check_outputs(tag);
    @(negedge i_clk);
    check({tag, "_pulse"}, o_valid, 1'b0);
  endtask

  task automatic do_flush();
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    m_armed  = 1'b0;
    m_seqErr = 1'b0;
    @(negedge i_clk);
    check("flush_seq", o_seqErr, 1'b0);
  endtask

  task automatic count_valids(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge i_clk);
      if (o_valid) n++;
    end
  endtask

  initial begin
    int n, cnt, rlow, acc;
    bit seen, acc_at_valid;
    logic [7:0] w, x, y, is, sd;

    // Reset values
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_outs", {o_winNum, o_ham, o_cov, o_dep}, 32'h0);
    check("rst_seq", o_seqErr, 1'b0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Basic result, checked against fixed values as well as the model
    send_pkt(8'h00, 8'h80, 8'h80, 8'h40, 8'h80, 0);
    model_pkt(8'h00, 8'h80, 8'h80, 8'h40, 8'h80);
    check("basic_fixed", {e_ham[7:0], e_cov[7:0], e_dep[7:0]}, 32'h7F8080);
    wait_result(17, "basic");

    // Zero denominator
    send_pkt(8'h01, 8'h10, 8'h00, 8'h00, 8'h10, 1);
    model_pkt(8'h01, 8'h10, 8'h00, 8'h00, 8'h10);
    wait_result(17, "zden");

    // Saturation high and low
    send_pkt(8'h02, 8'h20, 8'h10, 8'hFF, 8'h00, 0);
    model_pkt(8'h02, 8'h20, 8'h10, 8'hFF, 8'h00);
    wait_result(17, "sathi");
    send_pkt(8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    model_pkt(8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00);
    check("satlo_fixed", e_cov, 0);
    wait_result(17, "satlo");

    // Sequence check: 05 then 07 flags, sticky, cleared by flush; FF -> 00 wraps cleanly
    do_flush();
    send_pkt(8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    model_pkt(8'h05, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_result(17, "seq05");
    send_pkt(8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    model_pkt(8'h07, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_result(17, "seq07");
    send_pkt(8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    model_pkt(8'h08, 8'h01, 8'h02, 8'h03, 8'h04);
    wait_result(17, "seqsticky");
    do_flush();
    send_pkt(8'hFF, 8'h40, 8'h40, 8'h20, 8'h10, 0);
    model_pkt(8'hFF, 8'h40, 8'h40, 8'h20, 8'h10);
    wait_result(17, "seqFF");
    send_pkt(8'h00, 8'h40, 8'h40, 8'h20, 8'h10, 0);
    model_pkt(8'h00, 8'h40, 8'h40, 8'h20, 8'h10);
    wait_result(17, "seq00");

    // Backpressure: AA held through DIV, accepted once, in the o_valid cycle
    send_pkt(8'h01, 8'h30, 8'h60, 8'h50, 8'h0F, 0);
    model_pkt(8'h01, 8'h30, 8'h60, 8'h50, 8'h0F);
    i_data = 8'hAA;
    i_valid = 1'b1;
    rlow = 0;
    acc = 0;
    acc_at_valid = 1'b0;
    cnt = 0;
    while (acc == 0 && cnt < 60) begin
      @(negedge i_clk);
      cnt++;
      if (!o_ready) rlow++;
      if (o_valid) check_outputs("bp");
      if (o_ready) begin
        acc++;
        acc_at_valid = o_valid;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    check("bp_rlow", rlow, 16);
    check("bp_acc", acc, 1);
    check("bp_accv", acc_at_valid, 1'b1);
    put_byte(8'h10, 0);
    put_byte(8'h20, 0);
    put_byte(8'h08, 0);
    put_byte(8'h33, 0);
    model_pkt(8'hAA, 8'h10, 8'h20, 8'h08, 8'h33);
    wait_result(17, "bpnext");

    // Flush together with a 4th byte drops it; next packet completes normally, once
    do_flush();
    put_byte(8'h11, 0);
    put_byte(8'h22, 0);
    put_byte(8'h33, 0);
    i_data = 8'h44;
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    m_armed = 1'b0;
    m_seqErr = 1'b0;
    send_pkt(8'h20, 8'h40, 8'h40, 8'h10, 8'h30, 0);
    model_pkt(8'h20, 8'h40, 8'h40, 8'h10, 8'h30);
    wait_result(17, "flbyte");
    count_valids(25, n);
    check("flbyte_extra", n, 0);

    // Clock gate low for three cycles during DIV stretches latency by three
    send_pkt(8'h21, 8'h05, 8'h07, 8'h09, 8'h0B, 0);
    model_pkt(8'h21, 8'h05, 8'h07, 8'h09, 8'h0B);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(negedge i_clk);
      cnt++;
      if (o_valid) seen = 1'b1;
      if (cnt == 4) i_cg = 1'b0;
      if (cnt == 7) i_cg = 1'b1;
    end
    i_cg = 1'b1;
    check("cg_lat", cnt, 20);
    if (seen) check_outputs("cg");

    // Randomized packets against the model
    for (int k = 0; k < 16; k++) begin
      w  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(m_prev + 1);
      x  = 8'($urandom);
      y  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      is = 8'($urandom);
      sd = 8'($urandom);
      send_pkt(w, x, y, is, sd, 2);
      model_pkt(w, x, y, is, sd);
      wait_result(17, "rnd");
    end

    // Asynchronous reset mid-DIV
    send_pkt(8'h50, 8'h12, 8'h34, 8'h56, 8'h78, 0);
    repeat (6) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("arst_ready", o_ready, 1'b1);
    check("arst_valid", o_valid, 1'b0);
    check("arst_outs", {o_winNum, o_ham, o_cov, o_dep}, 32'h0);
    check("arst_seq", o_seqErr, 1'b0);
    m_armed = 1'b0;
    m_seqErr = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    count_valids(30, n);
    check("arst_novalid", n, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_corr_metric
`default_nettype wire
